// File: rtl/change_dispenser_if.sv
// Change-dispense interface between the vending core / hopper and the dispenser.
// The dispenser (slave) consumes the change request and hopper ack and drives the coin requests.
interface change_dispenser_if;
  logic       change_valid;
  logic [7:0] change;
  logic       coin_ack;
  logic       refill;
  logic       busy;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic       dispense_done;
  logic       short;
  logic [7:0] short_amount;
  logic [3:0] stock_low;

  modport slave (
    input  change_valid, change, coin_ack, refill,
    output busy, coin_req, coin_sel, dispense_done, short, short_amount, stock_low
  );

  modport master (
    output change_valid, change, coin_ack, refill,
    input  busy, coin_req, coin_sel, dispense_done, short, short_amount, stock_low
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin dispenser: pays out a change amount one coin at a time from four
// stocked tubes, largest denomination first, with jam timeout and shortfall report.
module change_dispenser #(
  parameter int unsigned VAL0        = 1,
  parameter int unsigned VAL1        = 5,
  parameter int unsigned VAL2        = 10,
  parameter int unsigned VAL3        = 20,
  parameter int unsigned INIT_COUNT  = 15,
  parameter int unsigned LOW_THRESH  = 2,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  change_dispenser_if.slave cd
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  // S_LOAD is a one-cycle accept stage so busy rises right after the strobe
  // while the first coin request follows two edges later.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SELECT,
    S_REQ,
    S_DONE
  } state_t;

  state_t       r_state,      w_state;
  logic [7:0]   r_remaining,  w_remaining;
  logic [7:0]   r_count [4];
  logic [7:0]   w_count [4];
  logic         r_busy,       w_busy;
  logic         r_coin_req,   w_coin_req;
  logic [1:0]   r_coin_sel,   w_coin_sel;
  logic         r_done,       w_done;
  logic         r_short,      w_short;
  logic [7:0]   r_short_amt,  w_short_amt;
  logic [TW-1:0] r_tmo,       w_tmo;

  logic         w_pick_ok;
  logic [1:0]   w_pick;
  logic [3:0]   w_stock_low;

  function automatic logic [7:0] f_val(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'(VAL0);
      2'd1:    return 8'(VAL1);
      2'd2:    return 8'(VAL2);
      default: return 8'(VAL3);
    endcase
  endfunction

  // Ascending scan: the last qualifying tube wins, i.e. the highest index.
  always_comb begin
    w_pick_ok = 1'b0;
    w_pick    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (f_val(2'(i)) <= r_remaining && r_count[i] != '0) begin
        w_pick_ok = 1'b1;
        w_pick    = 2'(i);
      end
    end
  end

  always_comb begin
    w_stock_low = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_stock_low[i] = (r_count[i] <= 8'(LOW_THRESH));
    end
  end

  always_comb begin
    w_state     = r_state;
    w_remaining = r_remaining;
    w_count     = r_count;
    w_busy      = r_busy;
    w_coin_req  = r_coin_req;
    w_coin_sel  = r_coin_sel;
    w_done      = 1'b0;
    w_short     = r_short;
    w_short_amt = r_short_amt;
    w_tmo       = r_tmo;

    case (r_state)
      S_IDLE: begin
        if (cd.change_valid) begin
          w_remaining = cd.change;
          w_short     = 1'b0;
          w_short_amt = '0;
          w_busy      = 1'b1;
          w_state     = S_LOAD;
        end else if (cd.refill) begin
          for (int unsigned i = 0; i < 4; i++) begin
            w_count[i] = 8'(INIT_COUNT);
          end
        end
      end

      S_LOAD: w_state = S_SELECT;

      S_SELECT: begin
        if (r_remaining == '0) begin
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_state = S_DONE;
        end else if (w_pick_ok) begin
          w_coin_sel = w_pick;
          w_coin_req = 1'b1;
          w_tmo      = '0;
          w_state    = S_REQ;
        end else begin
          w_short     = 1'b1;
          w_short_amt = r_remaining;
          w_done      = 1'b1;
          w_busy      = 1'b0;
          w_state     = S_DONE;
        end
      end

      S_REQ: begin
        if (cd.coin_ack) begin
          w_remaining         = r_remaining - f_val(r_coin_sel);
          w_count[r_coin_sel] = r_count[r_coin_sel] - 8'd1;
          w_coin_req          = 1'b0;
          w_state             = S_SELECT;
        end else if (r_tmo == TW'(ACK_TIMEOUT - 1)) begin
          w_coin_req  = 1'b0;
          w_short     = 1'b1;
          w_short_amt = r_remaining;
          w_done      = 1'b1;
          w_busy      = 1'b0;
          w_state     = S_DONE;
        end else begin
          w_tmo = r_tmo + TW'(1);
        end
      end

      S_DONE: w_state = S_IDLE;

      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_count[i] <= 8'(INIT_COUNT);
      end
      r_busy      <= 1'b0;
      r_coin_req  <= 1'b0;
      r_coin_sel  <= '0;
      r_done      <= 1'b0;
      r_short     <= 1'b0;
      r_short_amt <= '0;
      r_tmo       <= '0;
    end else begin
      r_state     <= w_state;
      r_remaining <= w_remaining;
      r_count     <= w_count;
      r_busy      <= w_busy;
      r_coin_req  <= w_coin_req;
      r_coin_sel  <= w_coin_sel;
      r_done      <= w_done;
      r_short     <= w_short;
      r_short_amt <= w_short_amt;
      r_tmo       <= w_tmo;
    end
  end

  assign cd.busy          = r_busy;
  assign cd.coin_req      = r_coin_req;
  assign cd.coin_sel      = r_coin_sel;
  assign cd.dispense_done = r_done;
  assign cd.short         = r_short;
  assign cd.short_amount  = r_short_amt;
  assign cd.stock_low     = w_stock_low;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy payout model queues expected
// coin selections and completion results; a monitor compares what the DUT presents.
module tb_change_dispenser;
  localparam int INIT = 15;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  change_dispenser_if cd();

  change_dispenser #(
    .VAL0(1), .VAL1(5), .VAL2(10), .VAL3(20),
    .INIT_COUNT(INIT), .LOW_THRESH(2), .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cd(cd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    int amt;
    int low;
  } res_t;

  int   vals [4] = '{1, 5, 10, 20};
  int   m_count [4];
  int   exp_sel_q [$];
  res_t exp_res_q [$];
  int   plan_q [$];
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   t           = 0;
  int   busy_cycles = 0;
  int   ack_delay   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not observed within bound (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(negedge clk);
    t++;
    if (cd.busy) busy_cycles++;
  endtask

  function automatic int model_low();
    int l = 0;
    for (int i = 0; i < 4; i++) if (m_count[i] <= 2) l |= (1 << i);
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_count[i] = INIT;
    exp_sel_q.delete();
    exp_res_q.delete();
  endtask

  // Greedy payout computed coin by coin; jam = index of the coin that never gets acked.
  task automatic plan(input int amt, input int jam);
    int   rem = amt;
    int   k   = 0;
    int   pick;
    res_t r;
    r.s   = 0;
    r.amt = 0;
    plan_q.delete();
    while (rem > 0) begin
      pick = -1;
      for (int i = 3; i >= 0; i--) begin
        if (vals[i] <= rem && m_count[i] > 0) begin
          pick = i;
          break;
        end
      end
      if (pick < 0) begin
        r.s   = 1;
        r.amt = rem;
        break;
      end
      plan_q.push_back(pick);
      exp_sel_q.push_back(pick);
      if (k == jam) begin
        r.s   = 1;
        r.amt = rem;
        break;
      end
      rem -= vals[pick];
      m_count[pick]--;
      k++;
    end
    r.low = model_low();
    exp_res_q.push_back(r);
  endtask

  task automatic hard_reset();
    reset_n         = 1'b0;
    cd.change_valid = 1'b0;
    cd.coin_ack     = 1'b0;
    cd.refill       = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},          int'(cd.busy),          0);
    check({tag, "_coin_req"},      int'(cd.coin_req),      0);
    check({tag, "_coin_sel"},      int'(cd.coin_sel),      0);
    check({tag, "_dispense_done"}, int'(cd.dispense_done), 0);
    check({tag, "_short"},         int'(cd.short),         0);
    check({tag, "_short_amount"},  int'(cd.short_amount),  0);
    check({tag, "_stock_low"},     int'(cd.stock_low),     0);
  endtask

  task automatic do_txn(input int amt, input int jam, input bit inject, input bit rst2);
    int n;
    bit ok = 1'b1;
    plan(amt, jam);
    cd.change       = 8'(amt);
    cd.change_valid = 1'b1;
    cd.refill       = ($urandom_range(0, 3) == 0);
    t           = 0;
    busy_cycles = 0;
    tick();
    cd.change_valid = 1'b0;
    cd.refill       = 1'b0;
    for (int k = 0; k < plan_q.size(); k++) begin
      n = 0;
      while (!cd.coin_req && n < 8) begin
        tick();
        n++;
      end
      if (!cd.coin_req) begin
        fail_now("coin_req_wait");
        ok = 1'b0;
        break;
      end
      if (k == 0) check("first_req_latency", t, 3);
      if (k == jam) begin
        n = 0;
        while (cd.coin_req && n < 40) begin
          tick();
          n++;
        end
        check("jam_req_cycles", n, 16);
      end else begin
        repeat (ack_delay) tick();
        cd.coin_ack = 1'b1;
        if (inject && k == 0) begin
          cd.change_valid = 1'b1;
          cd.change       = 8'd99;
          cd.refill       = 1'b1;
        end
        tick();
        cd.coin_ack     = 1'b0;
        cd.change_valid = 1'b0;
        cd.refill       = 1'b0;
        if (rst2 && k == 1) begin
          reset_n = 1'b0;
          model_reset();
          tick();
          reset_n = 1'b1;
          check_idle_outputs("abort");
          repeat (4) tick();
          return;
        end
      end
    end
    if (ok) begin
      n = 0;
      while (!cd.dispense_done && n < 40) begin
        tick();
        n++;
      end
      if (!cd.dispense_done) begin
        fail_now("dispense_done_wait");
        ok = 1'b0;
      end else if (amt == 0) begin
        check("zero_done_latency", t, 3);
        check("zero_busy_cycles", busy_cycles, 2);
      end
    end
    if (!ok) hard_reset();
    else tick();
  endtask

  bit prev_req = 1'b0;
  int held_sel = 0;

  always @(posedge clk) begin
    res_t r;
    #1;
    if (cd.coin_req && !prev_req) begin
      if (exp_sel_q.size() == 0) begin
        check("coin_req_unexpected", 1, 0);
      end else begin
        check("coin_sel", int'(cd.coin_sel), exp_sel_q.pop_front());
        check("short_cleared_on_accept", int'(cd.short), 0);
      end
    end else if (cd.coin_req) begin
      check("coin_sel_stable", int'(cd.coin_sel), held_sel);
    end
    if (cd.dispense_done) begin
      if (exp_res_q.size() == 0) begin
        check("dispense_done_unexpected", 1, 0);
      end else begin
        r = exp_res_q.pop_front();
        check("short", int'(cd.short), r.s);
        check("short_amount", int'(cd.short_amount), r.amt);
        check("stock_low", int'(cd.stock_low), r.low);
        check("busy_low_at_done", int'(cd.busy), 0);
      end
    end
    prev_req = cd.coin_req;
    held_sel = int'(cd.coin_sel);
  end

  initial begin
    int amt;
    int jam;
    bit inj;
    cd.change_valid = 1'b0;
    cd.change       = '0;
    cd.coin_ack     = 1'b0;
    cd.refill       = 1'b0;
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_idle_outputs("reset");

    ack_delay = 0;
    do_txn(37, -1, 1'b1, 1'b0);
    do_txn(0,  -1, 1'b0, 1'b0);
    do_txn(20,  0, 1'b0, 1'b0);
    do_txn(37, -1, 1'b0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      ack_delay = int'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        cd.refill = 1'b1;
        for (int j = 0; j < 4; j++) m_count[j] = INIT;
        @(negedge clk);
        cd.refill = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        cd.coin_ack = 1'b1;
        @(negedge clk);
        cd.coin_ack = 1'b0;
      end
      amt = int'($urandom_range(0, 255));
      jam = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1;
      inj = ($urandom_range(0, 3) == 0);
      do_txn(amt, jam, inj, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("sel_queue_drained", exp_sel_q.size(), 0);
    check("result_queue_drained", exp_res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
